sram_input_loader: RTL

Upstream feeder for the ten parallel input SRAM lanes of the accelerator. Accepts a serial stream of 16-bit activation words over a valid/ready handshake, packs every ten consecutive words into one row, and writes that row to all ten input SRAMs with a single shared address and write enable. It replaces the externally driven input-SRAM write enable and address once the control path is integrated.

---
 rtl/sram_input_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sram_input_loader.sv
// Packs a serial 16-bit activation stream into ten-lane rows for the input SRAMs.
// Define LOADER_ZERO_PAD_EN to write a partial final row with zero-filled lanes.
module sram_input_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2,
    output logic [DATA_W-1:0] d3,
    output logic [DATA_W-1:0] d4,
    output logic [DATA_W-1:0] d5,
    output logic [DATA_W-1:0] d6,
    output logic [DATA_W-1:0] d7,
    output logic [DATA_W-1:0] d8,
    output logic [DATA_W-1:0] d9,
    output logic [DATA_W-1:0] d10,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rows_written
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    localparam int                LANES     = 10;
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        LAST_LANE = 4'd9;

    state_t                         state_q, state_d;
    logic [3:0]                     lane_q, lane_d;
    logic [ADDR_W-1:0]              row_q, row_d;
    logic [ADDR_W:0]                rows_q, rows_d;
    logic [LANES-1:0][DATA_W-1:0]   buf_q, buf_d;
    logic [LANES-1:0][DATA_W-1:0]   dout_q, dout_d;
    logic                           last_q, last_d;
    logic                           pad_row;

`ifdef LOADER_ZERO_PAD_EN
    assign pad_row = 1'b1;
`else
    assign pad_row = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        row_d   = row_q;
        rows_d  = rows_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    lane_d  = '0;
                    row_d   = '0;
                    rows_d  = '0;
                    buf_d   = '0;
                    dout_d  = '0;
                    last_d  = 1'b0;
                end
            end
            FILL: begin
                if (in_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_q == 4'(i)) buf_d[i] = in_data;
                    end
                    if (lane_q == LAST_LANE || in_last) begin
                        last_d = in_last;
                        // Output lanes latch the finished row; the fill buffer restarts at zero.
                        if (lane_q == LAST_LANE || pad_row) begin
                            state_d = WRITE;
                            dout_d  = buf_d;
                        end else begin
                            state_d = DONE;
                        end
                        buf_d = '0;
                    end else begin
                        lane_d = lane_q + 4'd1;
                    end
                end
            end
            WRITE: begin
                rows_d = rows_q + 1'b1;
                lane_d = '0;
                if (last_q || row_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            row_q   <= '0;
            rows_q  <= '0;
            buf_q   <= '0;
            dout_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            row_q   <= row_d;
            rows_q  <= rows_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
        end
    end

    assign in_ready     = (state_q == FILL);
    assign we           = (state_q == WRITE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign address      = row_q;
    assign rows_written = rows_q;
    assign d1           = dout_q[0];
    assign d2           = dout_q[1];
    assign d3           = dout_q[2];
    assign d4           = dout_q[3];
    assign d5           = dout_q[4];
    assign d6           = dout_q[5];
    assign d7           = dout_q[6];
    assign d8           = dout_q[7];
    assign d9           = dout_q[8];
    assign d10          = dout_q[9];

endmodule
